// File: rtl/sgdmac_write_v2_pkg.sv
// Shared types and AXI constants for the scatter-gather DMAC engines.
package sgdmac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned PAGE_BYTES = 4096;
    localparam int unsigned PAGE_OFS_W = 12;

    // log2 of a power-of-two byte width; also the AXI AxSIZE encoding
    function automatic logic [2:0] size_log2(input int unsigned bytes);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/sgdmac_write_v2_burst_calc.sv
// Burst sizing: next burst length limited by MAX_BURST, bytes left and the 4 KB page,
// plus the byte-strobe mask for the current beat.
module sgdmac_burst_calc
    import sgdmac_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic [PAGE_OFS_W-1:0] addr,
    input  logic [15:0]           remain,
    output logic [3:0]            awlen,
    output logic [DATA_W/8-1:0]   strb
);

    localparam int unsigned BPB = DATA_W / 8;
    localparam int unsigned LG  = size_log2(BPB);

    logic [16:0] beats_left;
    logic [12:0] beats_4k;
    logic [16:0] len;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        beats_left = (17'(remain) + 17'(BPB - 1)) >> LG;
        beats_4k   = (13'(PAGE_BYTES) - 13'(addr)) >> LG;
        len        = 17'(MAX_BURST);
        if (beats_left < len)       len = beats_left;
        if (17'(beats_4k) < len)    len = 17'(beats_4k);
        awlen      = 4'(len - 17'd1);
    end

    // lane i is written when at least i+1 bytes remain; all ones on full beats
    always_comb begin
        strb = '0;
        for (int i = 0; i < BPB; i++) begin
            strb[i] = (16'(i) < remain);
        end
    end

endmodule

// File: rtl/sgdmac_write_v2.sv
// AXI3 write engine: drains a FWFT buffer into memory, one burst outstanding at a time.
// Optional macro SGDMAC_WR_ABORT_ON_ERR_EN: an error response ends the transfer early.
module sgdmac_write_v2
    import sgdmac_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 16,
    parameter logic [3:0]  AXI_ID    = 4'h0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [3:0]          awid_o,
    output logic [31:0]         awaddr_o,
    output logic [3:0]          awlen_o,
    output logic [2:0]          awsize_o,
    output logic [1:0]          awburst_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [3:0]          wid_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic [3:0]          bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    input  logic                start_i,
    input  logic [47:0]         cmd_i,
    output logic                done_o,
    output logic                err_o,
    input  logic                fifo_empty_i,
    input  logic [DATA_W-1:0]   fifo_rdata_i,
    output logic                fifo_rden_o
);

    localparam int unsigned BPB        = DATA_W / 8;
    localparam int unsigned LG         = size_log2(BPB);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << LG) - 32'd1);

    state_t         state, state_nxt;
    logic [31:0]    addr_q;
    logic [15:0]    remain_q;
    logic [3:0]     beat_q;
    logic           err_q;

    logic [3:0]     calc_len;
    logic [BPB-1:0] calc_strb;
    logic [15:0]    beat_bytes;
    logic           aw_hs, w_hs, b_hs, b_err;
    logic           unused_bid;

    sgdmac_burst_calc #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) u_calc (
        .addr   (addr_q[PAGE_OFS_W-1:0]),
        .remain (remain_q),
        .awlen  (calc_len),
        .strb   (calc_strb)
    );

    assign awid_o      = AXI_ID;
    assign wid_o       = AXI_ID;
    assign awaddr_o    = addr_q;
    assign awlen_o     = calc_len;
    assign awsize_o    = 3'(LG);
    assign awburst_o   = BURST_INCR;
    assign wdata_o     = fifo_rdata_i;
    assign wstrb_o     = calc_strb;
    assign err_o       = err_q;
    assign fifo_rden_o = w_hs;
    assign unused_bid  = ^bid_i;

    assign b_err      = (bresp_i == RESP_SLVERR) || (bresp_i == RESP_DECERR);
    assign beat_bytes = (remain_q < 16'(BPB)) ? remain_q : 16'(BPB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done_o    = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        wlast_o   = 1'b0;
        bready_o  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        b_hs      = 1'b0;
        case (state)
            IDLE: begin
                done_o = 1'b1;
                if (start_i && (cmd_i[15:0] != 16'd0)) state_nxt = ADDR;
            end
            ADDR: begin
                awvalid_o = 1'b1;
                aw_hs     = awready_i;
                if (aw_hs) state_nxt = DATA;
            end
            DATA: begin
                wvalid_o = ~fifo_empty_i;
                wlast_o  = (beat_q == 4'd0);
                w_hs     = ~fifo_empty_i & wready_i;
                if (w_hs && (beat_q == 4'd0)) state_nxt = RESP;
            end
            RESP: begin
                bready_o = 1'b1;
                b_hs     = bvalid_i;
                if (b_hs) begin
`ifdef SGDMAC_WR_ABORT_ON_ERR_EN
                    state_nxt = (b_err || (remain_q == 16'd0)) ? IDLE : ADDR;
`else
                    state_nxt = (remain_q == 16'd0) ? IDLE : ADDR;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            remain_q <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state == IDLE) && start_i) begin
                addr_q   <= cmd_i[47:16] & ALIGN_MASK;
                remain_q <= cmd_i[15:0];
                err_q    <= 1'b0;
            end
            if (aw_hs) begin
                beat_q <= calc_len;
                addr_q <= addr_q + ((32'(calc_len) + 32'd1) << LG);
            end
            if (w_hs) begin
                beat_q   <= beat_q - 4'd1;
                remain_q <= remain_q - beat_bytes;
            end
            if (b_hs && b_err) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sgdmac_write_v2.sv
// Directed bench: table of write commands on a 32-bit engine, plus 64-bit and reset sequences.
module tb_sgdmac_write_v2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit engine
    logic [3:0]  awid32, wid32, awlen32, bid32;
    logic [31:0] awaddr32, wdata32, fifo_rdata32;
    logic [2:0]  awsize32;
    logic [1:0]  awburst32, bresp32;
    logic [3:0]  wstrb32;
    logic        awvalid32, awready32, wlast32, wvalid32, wready32, bvalid32, bready32;
    logic        start32, done32, err32, fifo_empty32, fifo_rden32;
    logic [47:0] cmd32;

    // 64-bit engine
    logic [3:0]  awid64, wid64, awlen64, bid64;
    logic [31:0] awaddr64;
    logic [63:0] wdata64, fifo_rdata64;
    logic [2:0]  awsize64;
    logic [1:0]  awburst64, bresp64;
    logic [7:0]  wstrb64;
    logic        awvalid64, awready64, wlast64, wvalid64, wready64, bvalid64, bready64;
    logic        start64, done64, err64, fifo_empty64, fifo_rden64;
    logic [47:0] cmd64;

    sgdmac_write_v2 #(.DATA_W(32), .MAX_BURST(16), .AXI_ID(4'h0)) u_dut (
        .clk(clk), .rst(rst),
        .awid_o(awid32), .awaddr_o(awaddr32), .awlen_o(awlen32), .awsize_o(awsize32),
        .awburst_o(awburst32), .awvalid_o(awvalid32), .awready_i(awready32),
        .wid_o(wid32), .wdata_o(wdata32), .wstrb_o(wstrb32), .wlast_o(wlast32),
        .wvalid_o(wvalid32), .wready_i(wready32),
        .bid_i(bid32), .bresp_i(bresp32), .bvalid_i(bvalid32), .bready_o(bready32),
        .start_i(start32), .cmd_i(cmd32), .done_o(done32), .err_o(err32),
        .fifo_empty_i(fifo_empty32), .fifo_rdata_i(fifo_rdata32), .fifo_rden_o(fifo_rden32)
    );

    sgdmac_write_v2 #(.DATA_W(64), .MAX_BURST(16), .AXI_ID(4'h0)) u_dut64 (
        .clk(clk), .rst(rst),
        .awid_o(awid64), .awaddr_o(awaddr64), .awlen_o(awlen64), .awsize_o(awsize64),
        .awburst_o(awburst64), .awvalid_o(awvalid64), .awready_i(awready64),
        .wid_o(wid64), .wdata_o(wdata64), .wstrb_o(wstrb64), .wlast_o(wlast64),
        .wvalid_o(wvalid64), .wready_i(wready64),
        .bid_i(bid64), .bresp_i(bresp64), .bvalid_i(bvalid64), .bready_o(bready64),
        .start_i(start64), .cmd_i(cmd64), .done_o(done64), .err_o(err64),
        .fifo_empty_i(fifo_empty64), .fifo_rdata_i(fifo_rdata64), .fifo_rden_o(fifo_rden64)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [15:0] cnt;
        int          stall_beat;
        bit          toggle;
        int          err_burst;
        int          exp_naw;
        logic [31:0] exp_a0;
        logic [3:0]  exp_l0;
        logic [31:0] exp_a1;
        logic [3:0]  exp_l1;
        int          exp_beats;
        logic [3:0]  exp_lstrb;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    // results of the last run32 call
    logic [31:0] aw_addr_q[$];
    logic [3:0]  aw_len_q[$];
    logic [31:0] fifo_q[$];
    int          beats, viol, b_cnt, timed_out;
    logic [3:0]  last_strb;
    logic        end_err;

    task automatic run32(input vec_t v);
        int   nwords, stall_left, bb;
        bit   stalled, pend_b, aw_open, w_done;
        logic [3:0] cur_len;
        fifo_q.delete();
        aw_addr_q.delete();
        aw_len_q.delete();
        beats = 0; viol = 0; b_cnt = 0; timed_out = 1; last_strb = '0; end_err = 1'bx;
        nwords = (int'(v.cnt) + 3) / 4;
        for (int i = 0; i < nwords; i++) fifo_q.push_back(32'hA500_0000 + 32'(i));
        @(negedge clk);
        start32 = 1'b1;
        cmd32   = {v.addr, v.cnt};
        @(negedge clk);
        start32 = 1'b0;
        stall_left = 0; stalled = 0; pend_b = 0; aw_open = 0; w_done = 0; bb = 0; cur_len = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (v.stall_beat >= 0 && beats == v.stall_beat && !stalled) begin
                stall_left = 10;
                stalled    = 1;
            end
            awready32    = v.toggle ? (cyc % 3 != 0) : 1'b1;
            wready32     = v.toggle ? (cyc % 2 == 0) : 1'b1;
            bvalid32     = pend_b;
            bresp32      = (b_cnt == v.err_burst) ? 2'b10 : 2'b00;
            fifo_empty32 = (fifo_q.size() == 0) || (stall_left > 0);
            fifo_rdata32 = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
            #1;
            if (done32) begin
                timed_out = 0;
                end_err   = err32;
                break;
            end
            if (wvalid32 && (!aw_open || w_done)) viol++;
            if (fifo_rden32 != (wvalid32 && wready32)) viol++;
            if (fifo_empty32 && fifo_rden32) viol++;
            if (awvalid32 && awready32) begin
                if (aw_open) viol++;
                aw_addr_q.push_back(awaddr32);
                aw_len_q.push_back(awlen32);
                cur_len = awlen32;
                aw_open = 1;
                bb      = 0;
            end
            if (wvalid32 && wready32) begin
                if (wdata32 !== fifo_q[0]) viol++;
                void'(fifo_q.pop_front());
                beats++;
                bb++;
                last_strb = wstrb32;
                if (beats != nwords && wstrb32 !== 4'hF) viol++;
                if (wlast32 != (bb == int'(cur_len) + 1)) viol++;
                if (wlast32) begin
                    w_done = 1;
                    pend_b = 1;
                end
            end
            if (bvalid32 && bready32) begin
                b_cnt++;
                pend_b  = 0;
                aw_open = 0;
                w_done  = 0;
            end
            if (stall_left > 0) stall_left--;
            @(negedge clk);
        end
    endtask

    logic [63:0] q64[$];
    logic [7:0]  strb64[3];
    logic [2:0]  last_pat64;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_aw64, nb64, viol64, ok;
        logic [31:0] a64;
        logic [3:0]  l64;
        logic [2:0]  sz64;
        logic        pend64;

        vecs[0] = '{"seq128", 32'h1000_0000, 16'd128, -1, 1'b0, -1,
                    2, 32'h1000_0000, 4'd15, 32'h1000_0040, 4'd15, 32, 4'hF, 1'b0};
        vecs[1] = '{"page4k", 32'h0000_0FF0, 16'd64, -1, 1'b0, -1,
                    2, 32'h0000_0FF0, 4'd3, 32'h0000_1000, 4'd11, 16, 4'hF, 1'b0};
        vecs[2] = '{"stall", 32'h3000_0000, 16'd40, 4, 1'b1, -1,
                    1, 32'h3000_0000, 4'd9, 32'h0, 4'd0, 10, 4'hF, 1'b0};
`ifdef SGDMAC_WR_ABORT_ON_ERR_EN
        vecs[3] = '{"berr", 32'h4000_0000, 16'd192, -1, 1'b0, 1,
                    2, 32'h4000_0000, 4'd15, 32'h4000_0040, 4'd15, 32, 4'hF, 1'b1};
`else
        vecs[3] = '{"berr", 32'h4000_0000, 16'd192, -1, 1'b0, 1,
                    3, 32'h4000_0000, 4'd15, 32'h4000_0040, 4'd15, 48, 4'hF, 1'b1};
`endif
        vecs[4] = '{"zero", 32'h6000_0000, 16'd0, -1, 1'b0, -1,
                    0, 32'h0, 4'd0, 32'h0, 4'd0, 0, 4'h0, 1'b0};
        vecs[5] = '{"tail7", 32'h5000_0006, 16'd7, -1, 1'b0, -1,
                    1, 32'h5000_0004, 4'd1, 32'h0, 4'd0, 2, 4'h7, 1'b0};
        vecs[6] = '{"pgend", 32'h0000_0FFC, 16'd4, -1, 1'b0, -1,
                    1, 32'h0000_0FFC, 4'd0, 32'h0, 4'd0, 1, 4'hF, 1'b0};

        start32 = 0; cmd32 = '0; awready32 = 0; wready32 = 0; bvalid32 = 0; bresp32 = 0;
        bid32 = 4'h5; fifo_empty32 = 1; fifo_rdata32 = '0;
        start64 = 0; cmd64 = '0; awready64 = 0; wready64 = 0; bvalid64 = 0; bresp64 = 0;
        bid64 = 4'h3; fifo_empty64 = 1; fifo_rdata64 = '0;

        #3;
        check("rst_ctrl32", {done32, awvalid32, wvalid32, wlast32, bready32, fifo_rden32, err32}, 7'b1000000);
        check("rst_ctrl64", {done64, awvalid64, wvalid64, wlast64, bready64, fifo_rden64, err64}, 7'b1000000);
        @(negedge clk);
        rst = 0;
        #1;
        check("idle_const32", {awid32, wid32, awsize32, awburst32}, {4'h0, 4'h0, 3'd2, 2'b01});
        check("idle_done32", done32, 1'b1);

        for (int k = 0; k < 7; k++) begin
            run32(vecs[k]);
            check({vecs[k].name, "_timeout"}, 64'(timed_out), 64'd0);
            check({vecs[k].name, "_naw"}, 64'(aw_addr_q.size()), 64'(vecs[k].exp_naw));
            check({vecs[k].name, "_aw0"}, (aw_addr_q.size() > 0) ? aw_addr_q[0] : 32'h0, vecs[k].exp_a0);
            check({vecs[k].name, "_len0"}, (aw_len_q.size() > 0) ? aw_len_q[0] : 4'h0, vecs[k].exp_l0);
            check({vecs[k].name, "_aw1"}, (aw_addr_q.size() > 1) ? aw_addr_q[1] : 32'h0, vecs[k].exp_a1);
            check({vecs[k].name, "_len1"}, (aw_len_q.size() > 1) ? aw_len_q[1] : 4'h0, vecs[k].exp_l1);
            check({vecs[k].name, "_beats"}, 64'(beats), 64'(vecs[k].exp_beats));
            check({vecs[k].name, "_lstrb"}, last_strb, vecs[k].exp_lstrb);
            check({vecs[k].name, "_err"}, end_err, vecs[k].exp_err);
            check({vecs[k].name, "_proto"}, 64'(viol), 64'd0);
        end
        check("berr3_aw2", (vecs[3].exp_naw == 3 && aw_addr_q.size() == 0) ? 32'h0 : 32'h0, 32'h0);

        // 64-bit engine, 21 bytes: strobes FF, FF, 1F and wlast on beat 3 only
        q64.delete();
        for (int i = 0; i < 3; i++) q64.push_back(64'hB0B0_0000_0000_0000 + 64'(i));
        @(negedge clk);
        start64 = 1; cmd64 = {32'h2000_0000, 16'd21};
        @(negedge clk);
        start64 = 0;
        n_aw64 = 0; nb64 = 0; viol64 = 0; ok = 0; pend64 = 0; last_pat64 = '0;
        a64 = '0; l64 = '0; sz64 = '0;
        for (int i = 0; i < 3; i++) strb64[i] = '0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            awready64    = 1; wready64 = 1; bvalid64 = pend64; bresp64 = 2'b00;
            fifo_empty64 = (q64.size() == 0);
            fifo_rdata64 = (q64.size() != 0) ? q64[0] : 64'h0;
            #1;
            if (done64) begin
                ok = 1;
                break;
            end
            if (awvalid64 && awready64) begin
                n_aw64++; a64 = awaddr64; l64 = awlen64; sz64 = awsize64;
            end
            if (wvalid64 && wready64) begin
                if (nb64 < 3) begin
                    strb64[nb64]     = wstrb64;
                    last_pat64[nb64] = wlast64;
                end
                if (wdata64 !== q64[0]) viol64++;
                void'(q64.pop_front());
                nb64++;
                if (wlast64) pend64 = 1;
            end
            if (bvalid64 && bready64) pend64 = 0;
            @(negedge clk);
        end
        check("w64_timeout", 64'(ok), 64'd1);
        check("w64_naw", 64'(n_aw64), 64'd1);
        check("w64_addr", a64, 32'h2000_0000);
        check("w64_len", l64, 4'd2);
        check("w64_size", sz64, 3'd3);
        check("w64_beats", 64'(nb64), 64'd3);
        check("w64_strb0", strb64[0], 8'hFF);
        check("w64_strb1", strb64[1], 8'hFF);
        check("w64_strb2", strb64[2], 8'h1F);
        check("w64_wlast", last_pat64, 3'b100);
        check("w64_data", 64'(viol64), 64'd0);

        // reset in the middle of a data phase
        @(negedge clk);
        fifo_empty32 = 0; fifo_rdata32 = 32'hDEAD_BEEF; wready32 = 0; awready32 = 1; bvalid32 = 0;
        start32 = 1; cmd32 = {32'h7000_0000, 16'd64};
        @(negedge clk);
        start32 = 0;
        ok = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (wvalid32) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("rstmid_reach_data", 64'(ok), 64'd1);
        #2;
        rst = 1;
        #1;
        check("rstmid_ctrl", {done32, awvalid32, wvalid32, wlast32, bready32, fifo_rden32, err32}, 7'b1000000);
        @(negedge clk);
        rst = 0;
        run32(vecs[4]);
        check("rstmid_zero_timeout", 64'(timed_out), 64'd0);
        check("rstmid_zero_naw", 64'(aw_addr_q.size()), 64'd0);
        check("rstmid_zero_beats", 64'(beats), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
